// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter and its coefficient programmer.
// State encodings and the coefficient address width.
package fir_pkg;

  localparam int ADDR_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CHECK,
    ST_DONE,
    ST_FAIL
  } fir_state_e;

  function automatic logic is_rest(input fir_state_e s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_FAIL);
  endfunction

endpackage

// File: rtl/fir_coeff_prog.sv
// Programs the filter coefficient memory, reads it back to verify,
// and gates the upstream sample stream until verification passes.
module fir_coeff_prog
  import fir_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N*DATA_WIDTH-1:0] coeff_in,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [ADDR_WIDTH-1:0]   err_addr,
  output logic                    fir_we_coeff,
  output logic [ADDR_WIDTH-1:0]   fir_addr_coeff,
  output logic [DATA_WIDTH-1:0]   fir_data_coeff_i,
  input  logic [DATA_WIDTH-1:0]   fir_data_coeff_o,
  input  logic                    s_valid,
  input  logic [DATA_WIDTH-1:0]   s_sample,
  output logic                    s_ready,
  output logic                    fir_valid,
  output logic [DATA_WIDTH-1:0]   fir_sample
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N - 1);

  typedef logic [DATA_WIDTH-1:0] word_t;

  fir_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] nidx;
  word_t shadow_q [N];
  word_t shadow_d [N];

  logic we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  word_t wdata_q, wdata_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic error_q, error_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic mis_q, mis_d;
  logic cmp_vld_q, cmp_vld_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic s_ready_q, s_ready_d;
  logic fvalid_q, fvalid_d;
  word_t fsample_q, fsample_d;

  logic xfer;
  logic cur_mis;
  logic any_mis;

  assign nidx = idx_q + 1'b1;
  assign xfer = s_valid & s_ready_q;

  // Readback lags the address by one cycle, so compare against
  // the index that was on the bus in the previous cycle.
  assign cur_mis = cmp_vld_q &&
                   (fir_data_coeff_o != shadow_q[rd_idx_q]);
  assign any_mis = mis_q | cur_mis;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    we_d       = 1'b0;
    addr_d     = '0;
    wdata_d    = '0;
    busy_d     = 1'b0;
    done_d     = done_q;
    error_d    = error_q;
    err_addr_d = err_addr_q;
    mis_d      = mis_q;
    cmp_vld_d  = 1'b0;
    rd_idx_d   = idx_q[IW-1:0];
    s_ready_d  = 1'b0;
    fvalid_d   = xfer;
    fsample_d  = xfer ? s_sample : fsample_q;

    if (cur_mis) begin
      mis_d = 1'b1;
      if (!mis_q) err_addr_d = ADDR_WIDTH'(rd_idx_q);
    end

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          for (int k = 0; k < N; k++)
            shadow_d[k] = coeff_in[k*DATA_WIDTH +: DATA_WIDTH];
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_addr_d = '0;
          mis_d      = 1'b0;
          idx_d      = '0;
          state_d    = ST_WRITE;
          we_d       = 1'b1;
          addr_d     = '0;
          wdata_d    = coeff_in[DATA_WIDTH-1:0];
          busy_d     = 1'b1;
        end else if (state_q == ST_DONE) begin
          s_ready_d = 1'b1;
        end
      end
      ST_WRITE: begin
        busy_d = 1'b1;
        if (idx_q == LAST) begin
          state_d = ST_READ;
          idx_d   = '0;
        end else begin
          idx_d   = nidx;
          we_d    = 1'b1;
          addr_d  = nidx;
          wdata_d = shadow_q[nidx[IW-1:0]];
        end
      end
      ST_READ: begin
        busy_d    = 1'b1;
        cmp_vld_d = 1'b1;
        if (idx_q == LAST) begin
          state_d = ST_CHECK;
          idx_d   = '0;
        end else begin
          idx_d  = nidx;
          addr_d = nidx;
        end
      end
      ST_CHECK: begin
        state_d   = any_mis ? ST_FAIL : ST_DONE;
        done_d    = !any_mis;
        error_d   = any_mis;
        s_ready_d = !any_mis;
      end
      default: state_d = ST_IDLE;
    endcase

    // A start outside the rest states never reaches the branch above.
    if (!is_rest(state_q) && start) state_d = state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      for (int k = 0; k < N; k++) shadow_q[k] <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
      mis_q      <= 1'b0;
      cmp_vld_q  <= 1'b0;
      rd_idx_q   <= '0;
      s_ready_q  <= 1'b0;
      fvalid_q   <= 1'b0;
      fsample_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
      mis_q      <= mis_d;
      cmp_vld_q  <= cmp_vld_d;
      rd_idx_q   <= rd_idx_d;
      s_ready_q  <= s_ready_d;
      fvalid_q   <= fvalid_d;
      fsample_q  <= fsample_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign err_addr         = err_addr_q;
  assign fir_we_coeff     = we_q;
  assign fir_addr_coeff   = addr_q;
  assign fir_data_coeff_i = wdata_q;
  assign s_ready          = s_ready_q;
  assign fir_valid        = fvalid_q;
  assign fir_sample       = fsample_q;

endmodule

// File: tb/tb_fir_coeff_prog.sv
// Randomized self-checking bench for fir_coeff_prog with a
// behavioural coefficient memory standing in for the filter.
module tb_fir_coeff_prog;

  localparam int N  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [N*DW-1:0] coeff_in = '0;
  logic          busy, done, error;
  logic [3:0]    err_addr;
  logic          fir_we_coeff;
  logic [3:0]    fir_addr_coeff;
  logic [DW-1:0] fir_data_coeff_i;
  logic [DW-1:0] fir_data_coeff_o = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_sample = '0;
  logic          s_ready, fir_valid;
  logic [DW-1:0] fir_sample;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] fmem [16];
  logic [15:0]   corrupt = '0;
  bit            was_done = 0;

  fir_coeff_prog #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .coeff_in(coeff_in),
    .busy(busy), .done(done), .error(error), .err_addr(err_addr),
    .fir_we_coeff(fir_we_coeff), .fir_addr_coeff(fir_addr_coeff),
    .fir_data_coeff_i(fir_data_coeff_i),
    .fir_data_coeff_o(fir_data_coeff_o),
    .s_valid(s_valid), .s_sample(s_sample), .s_ready(s_ready),
    .fir_valid(fir_valid), .fir_sample(fir_sample)
  );

  always #5 clk = ~clk;

  // Filter model: writable memory, registered readback, optional fault.
  always @(posedge clk) begin
    if (fir_we_coeff) fmem[fir_addr_coeff] <= fir_data_coeff_i;
    fir_data_coeff_o <= corrupt[fir_addr_coeff] ? 16'h00FF
                                                : fmem[fir_addr_coeff];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(error), 0);
    chk({tag, "_ea"}, 32'(err_addr), 0);
    chk({tag, "_we"}, 32'(fir_we_coeff), 0);
    chk({tag, "_addr"}, 32'(fir_addr_coeff), 0);
    chk({tag, "_wd"}, 32'(fir_data_coeff_i), 0);
    chk({tag, "_rdy"}, 32'(s_ready), 0);
    chk({tag, "_fv"}, 32'(fir_valid), 0);
    chk({tag, "_fs"}, 32'(fir_sample), 0);
  endtask

  // Starts a run and checks every cycle up to the DONE/FAIL cycle.
  task automatic run_prog(input logic [N*DW-1:0] cf,
                          input logic [N-1:0] cmask,
                          input int bstart, input bit xf);
    bit exp_fail = 0;
    int exp_ea = 0;
    logic [DW-1:0] xs;
    for (int k = 0; k < N; k++)
      if (!exp_fail && cmask[k] && cf[k*DW +: DW] != 16'h00FF) begin
        exp_fail = 1;
        exp_ea = k;
      end
    @(negedge clk);
    corrupt = 16'(cmask);
    coeff_in = cf;
    start = 1'b1;
    xs = DW'($urandom);
    s_valid = xf;
    s_sample = xs;
    @(negedge clk);
    start = 1'b0;
    chk("start_fv", 32'(fir_valid), 32'(xf && was_done));
    if (xf && was_done) chk("start_fs", 32'(fir_sample), 32'(xs));
    for (int c = 1; c <= 2*N+2; c++) begin
      chk("busy", 32'(busy), 32'(c <= 2*N+1));
      chk("rdy", 32'(s_ready), 32'(c == 2*N+2 && !exp_fail));
      if (c <= N) begin
        chk("we", 32'(fir_we_coeff), 1);
        chk("waddr", 32'(fir_addr_coeff), 32'(c-1));
        chk("wdata", 32'(fir_data_coeff_i), 32'(cf[(c-1)*DW +: DW]));
      end else begin
        chk("we0", 32'(fir_we_coeff), 0);
        chk("wd0", 32'(fir_data_coeff_i), 0);
        chk("raddr", 32'(fir_addr_coeff),
            (c <= 2*N) ? 32'(c-N-1) : 0);
      end
      if (c > 1) chk("no_xfer", 32'(fir_valid), 0);
      if (c == 2*N+2) begin
        chk("done", 32'(done), 32'(!exp_fail));
        chk("error", 32'(error), 32'(exp_fail));
        chk("err_addr", 32'(err_addr), exp_fail ? 32'(exp_ea) : 0);
      end
      s_valid = (c < 2*N+2) ? 1'($urandom_range(0, 1)) : 1'b0;
      s_sample = DW'($urandom);
      start = (c == bstart);
      if (c < 2*N+2) @(negedge clk);
    end
    start = 1'b0;
    was_done = !exp_fail;
  endtask

  task automatic stream(input int n);
    logic [DW-1:0] exp_s = fir_sample;
    bit v;
    for (int i = 0; i < n; i++) begin
      v = 1'($urandom_range(0, 1));
      s_valid = v;
      s_sample = DW'($urandom);
      if (v) exp_s = s_sample;
      @(negedge clk);
      chk("st_fv", 32'(fir_valid), 32'(v && was_done));
      chk("st_fs", 32'(fir_sample), was_done ? 32'(exp_s) : 32'(fir_sample));
    end
    s_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) fmem[i] = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk_all_zero("rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("idle");

    // Nominal
    run_prog({16'd4, 16'd3, 16'd2, 16'd1}, 4'b0000, 0, 0);
    s_valid = 1'b1;
    s_sample = 16'h0005;
    @(negedge clk);
    chk("fv5", 32'(fir_valid), 1);
    chk("fs5", 32'(fir_sample), 32'h5);
    s_sample = 16'h0006;
    @(negedge clk);
    chk("fv6", 32'(fir_valid), 1);
    chk("fs6", 32'(fir_sample), 32'h6);
    s_valid = 1'b0;
    @(negedge clk);
    chk("fv_off", 32'(fir_valid), 0);
    chk("fs_hold", 32'(fir_sample), 32'h6);
    stream(6);

    // Restart from DONE with a transfer in the start cycle; mismatch at 2
    run_prog({16'd4, 16'd3, 16'd2, 16'd1}, 4'b0100, 0, 1);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      @(negedge clk);
      chk("fail_rdy", 32'(s_ready), 0);
      chk("fail_fv", 32'(fir_valid), 0);
    end
    s_valid = 1'b0;

    // Double mismatch
    run_prog({16'h1234, 16'hABCD, 16'h0F0F, 16'h7777}, 4'b1010, 0, 0);

    // Start during busy is ignored
    run_prog({DW'($urandom), DW'($urandom), DW'($urandom),
              DW'($urandom)}, 4'b0000, 3, 0);

    // Reset mid-WRITE at cycle 2
    @(negedge clk);
    coeff_in = {16'd9, 16'd8, 16'd7, 16'd6};
    corrupt = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_we", 32'(fir_we_coeff), 1);
    rst = 1'b1;
    #1;
    chk_all_zero("async");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_we", 32'(fir_we_coeff), 0);
    end
    rst = 1'b0;
    was_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_we", 32'(fir_we_coeff), 0);
      chk("post_busy", 32'(busy), 0);
    end
    run_prog({16'd9, 16'd8, 16'd7, 16'd6}, 4'b0000, 0, 0);

    // Random runs
    for (int r = 0; r < 8; r++) begin
      run_prog({DW'($urandom), DW'($urandom), DW'($urandom),
                DW'($urandom)},
               4'($urandom_range(0, 3) == 0 ? 0 : $urandom),
               ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2*N+1) : 0,
               1'($urandom_range(0, 1)));
      stream(4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_coeff_prog.md
FIR_COEFF_PROG -- requirements
Module: fir_coeff_prog

Interface
REQ-001 Parameter: N, 4, number of coefficients (1..16).
REQ-002 Parameter: DATA_WIDTH, 16, coefficient and sample width.
REQ-003 The block SHALL have exactly one clock and an asynchronous, active-high reset. The clock port is clk. The reset port is rst.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  single-cycle request to program and verify the filter.
REQ-007 coeff_in  in  N*DATA_WIDTH  flat coefficient vector; coefficient k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 busy  out  1  high while programming or verifying.
REQ-009 done  out  1  sticky high after a successful readback.
REQ-010 error  out  1  sticky high after a readback mismatch.
REQ-011 err_addr  out  4  address of the first mismatching coefficient.
REQ-012 fir_we_coeff  out  1  coefficient write enable to the filter.
REQ-013 fir_addr_coeff  out  4  coefficient address to the filter.
REQ-014 fir_data_coeff_i  out  DATA_WIDTH  coefficient write data to the filter.
REQ-015 fir_data_coeff_o  in  DATA_WIDTH  coefficient readback from the filter; registered there with 1-cycle latency.
REQ-016 s_valid  in  1  upstream sample valid.
REQ-017 s_sample  in  DATA_WIDTH  upstream sample.
REQ-018 s_ready  out  1  upstream ready.
REQ-019 fir_valid  out  1  sample strobe to the filter.
REQ-020 fir_sample  out  DATA_WIDTH  sample to the filter.

Function
REQ-021 The FSM SHALL have six states: IDLE, WRITE, READ, CHECK, DONE and FAIL. All outputs SHALL be registered.
REQ-022 A start sampled in IDLE, DONE or FAIL SHALL:
- capture coeff_in into a shadow array;
- clear done, error and err_addr;
- zero the index;
- enter WRITE.
REQ-023 A start sampled in WRITE, READ or CHECK SHALL be ignored.
REQ-024 Write timing, with cycle 0 being the cycle start is sampled:
- cycles 1..N: fir_we_coeff=1, fir_addr_coeff=k, fir_data_coeff_i=shadow[k], for k=0..N-1;
- then the FSM enters READ.
REQ-025 Read timing:
- cycles N+1..2N: fir_we_coeff=0 and fir_addr_coeff=k, for k=0..N-1;
- cycle 2N+1 is CHECK.
REQ-026 In cycles N+2..2N+1, fir_data_coeff_o SHALL be compared with shadow[k-1]. The comparison is pipelined exactly one cycle behind the address.
REQ-027 The first mismatch SHALL latch err_addr. Later mismatches SHALL NOT overwrite err_addr.
REQ-028 In cycle 2N+2 (cycle 10 for N=4):
- busy SHALL drop;
- the FSM SHALL enter DONE (done=1) if no mismatch occurred, otherwise FAIL (error=1).
REQ-029 busy SHALL be high in cycles 1..2N+1 and low otherwise.
REQ-030 Outside WRITE, fir_we_coeff SHALL be 0 and fir_data_coeff_i SHALL hold 0.
REQ-031 Outside WRITE and READ, fir_addr_coeff SHALL be 0. Address bits above the index width SHALL be 0.
REQ-032 s_ready SHALL be 1 only in DONE.
REQ-033 Sample forwarding:
- fir_valid SHALL be registered s_valid AND s_ready;
- fir_sample SHALL load s_sample only on that transfer and otherwise hold its value;
- latency is 1 cycle.
REQ-034 A transfer accepted in the cycle a restart start is sampled SHALL still be forwarded. s_ready SHALL be 0 from the next cycle.
REQ-035 The comparison SHALL be a bitwise equality over the full DATA_WIDTH. There is no sign extension or truncation.

Reset
REQ-036 While rst is high:
- the FSM SHALL be in IDLE;
- every output SHALL be 0;
- the shadow array and index SHALL be 0.
REQ-037 Reset asserted mid-operation SHALL abort immediately with no further filter writes. After release the block SHALL wait in IDLE for start.

Structure
REQ-038 The state encodings and ADDR_WIDTH=4 SHALL reside in the shared package fir_pkg, which is used by the filter and this block.
REQ-039 The block SHALL be a single module with no sub-module. Shadow storage is an N-entry register array.

Verification
REQ-040 The bench SHALL cover these scenarios:
- Nominal: N=4, coeff_in={4,3,2,1} (k3..k0), behavioural filter model -> writes (0,1),(1,2),(2,3),(3,4) in cycles 1..4; done=1 and busy=0 at cycle 10; error=0.
- Mismatch: model corrupts address 2 (returns 0x00FF) -> error=1, err_addr=2, done=0, s_ready stays 0.
- Double mismatch: addresses 1 and 3 corrupted -> err_addr=1.
- Busy start: second start at cycle 3 -> ignored; write sequence unchanged; done at cycle 10.
- Streaming: after done, s_valid=1 with samples 0x0005,0x0006 -> fir_valid high and fir_sample 0x0005,0x0006 one cycle later; no transfers before done.
- Reset mid-WRITE at cycle 2 -> all outputs 0 asynchronously; no further fir_we_coeff; a new start completes normally.
